segre_wb_arbiter: RTL and testbench
===================================

Name: segre_wb_arbiter

Overview:
- Parametrised writeback stage between N execution pipelines (EX, MEM, RVM, ...) and a single register-file write port.
- Each pipeline pushes results into its own FIFO. A round-robin arbiter drains one result per cycle into registered RF write outputs.
- Reports per-register pending status to decode so it can stall, and flags cross-pipe write-after-write (WAW) ordering violations.

Parameters:
- NUM_PIPES, 3, number of producing pipelines (index 0 = EX, 1 = MEM, 2 = RVM by convention).
- FIFO_DEPTH, 4, entries per pipe FIFO; power of two, >= 2.
- DATA_W, 32, result data width.
- REG_AW, 5, register address width.

Ports:
- clk_i  in  1  clock.
- rsn_i  in  1  reset.
- res_we_i  in  NUM_PIPES  per-pipe push request.
- res_waddr_i  in  NUM_PIPES*REG_AW  per-pipe destination register, pipe p at slice [p*REG_AW +: REG_AW].
- res_data_i  in  NUM_PIPES*DATA_W  per-pipe result data, same slicing.
- full_o  out  NUM_PIPES  per-pipe FIFO full; the producing pipe must stall.
- rf_we_o  out  1  RF write enable.
- rf_waddr_o  out  REG_AW  RF write address.
- rf_data_o  out  DATA_W  RF write data.
- pend_raddr_i  in  2*REG_AW  two decode source-register queries (rs1, rs2).
- pend_o  out  2  query k has a pending write.
- waw_err_o  out  1  sticky cross-pipe WAW violation.

Behaviour:
- Interface: one clock clk_i; reset rsn_i is asynchronous and active-low.
- Reset values: all FIFOs empty; rf_we_o=0, rf_waddr_o=0, rf_data_o=0; waw_err_o=0; round-robin pointer=0; full_o=0.
- Reset mid-operation discards all queued entries; no RF write follows reset deassertion until a new push.
- Push rules:
  - Pipe p pushes at a rising edge when res_we_i[p]=1, full_o[p]=0 and its waddr != 0.
  - A push with waddr == 0 is dropped silently.
  - A push while full_o[p]=1 is rejected, even if the same FIFO pops in that cycle.
- full_o[p] = (count[p] == FIFO_DEPTH). It is combinational from the count registers only, never from res_we_i.
- Simultaneous push and pop on a non-full FIFO: both occur; count is unchanged.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. Count is log2(FIFO_DEPTH)+1 bits.
- Arbitration, each cycle:
  - Grant the first non-empty FIFO at or after the pointer, searching upward modulo NUM_PIPES.
  - Pop its head into the output registers at the edge.
  - Set the pointer to (granted+1) mod NUM_PIPES.
  - If all FIFOs are empty: no pop, pointer unchanged, rf_we_o=0 next cycle. rf_waddr_o and rf_data_o hold their previous values.
- Latency: a push at edge E appears on rf_*_o in the cycle after edge E+1 when uncontended. Sustained throughput is 1 write per cycle total.
- Ordering: results within one pipe retire in FIFO order. No ordering is guaranteed across pipes.
- pend_o[k]=1 when pend_raddr_i[k] != 0 and it matches any valid FIFO entry or (rf_we_o && rf_waddr_o). Purely combinational.
- waw_err_o:
  - Set at an edge where a push from pipe p targets an address held by a valid entry in a FIFO q != p.
  - Also set if that address equals the entry being popped from q in the same cycle.
  - It stays set until reset.

Test Plan:
- Single push, pipe 0, waddr=5, data=0xDEAD_BEEF -> rf_we_o=1, rf_waddr_o=5, rf_data_o=0xDEADBEEF two edges after the push, for exactly one cycle.
- All three pipes push every cycle for 12 cycles (DEPTH=4), starting with pointer=0 -> writes alternate pipe0,1,2,0,...; full_o rises on each pipe once its FIFO holds 4. No rejected push is ever written; the accepted entry count equals the write count after draining.
- Pipe 1 fills to 4 entries, then pushes and pops in the same cycle -> push rejected, count becomes 3; 6 more push/pop pairs while not full -> pointers wrap, data order preserved.
- Pipe 2 queues waddr=7; decode queries rs1=7, rs2=0 -> pend_o=2'b01 until the cycle after rf_we_o for reg 7 drops.
- Pipe 0 holds waddr=9 pending, then pipe 1 pushes waddr=9 -> waw_err_o=1 from the next cycle, stays 1 after both drain; assert rsn_i=0 -> waw_err_o=0 and all outputs zero immediately.
- Pushes with waddr=0 on all pipes -> no RF write, pend_o=0, full_o unchanged.

Source files
------------

// File: rtl/segre_wb_arbiter_if.sv
// Writeback bus between the execution pipelines, decode's pending query and the RF write port.
// The arbiter sits on the slave side; whatever drives results and queries uses the master side.
interface segre_wb_arbiter_if #(
    parameter int NUM_PIPES = 3,
    parameter int DATA_W    = 32,
    parameter int REG_AW    = 5
);
    logic [NUM_PIPES-1:0]        res_we_i;
    logic [NUM_PIPES*REG_AW-1:0] res_waddr_i;
    logic [NUM_PIPES*DATA_W-1:0] res_data_i;
    logic [NUM_PIPES-1:0]        full_o;
    logic                        rf_we_o;
    logic [REG_AW-1:0]           rf_waddr_o;
    logic [DATA_W-1:0]           rf_data_o;
    logic [2*REG_AW-1:0]         pend_raddr_i;
    logic [1:0]                  pend_o;
    logic                        waw_err_o;

    modport slave (
        input  res_we_i, res_waddr_i, res_data_i, pend_raddr_i,
        output full_o, rf_we_o, rf_waddr_o, rf_data_o, pend_o, waw_err_o
    );

    modport master (
        output res_we_i, res_waddr_i, res_data_i, pend_raddr_i,
        input  full_o, rf_we_o, rf_waddr_o, rf_data_o, pend_o, waw_err_o
    );
endinterface

// File: rtl/segre_wb_arbiter.sv
// Writeback stage: one result FIFO per pipeline, round-robin drained into a registered RF write port,
// with per-register pending lookup for decode and a sticky cross-pipe WAW flag.
module segre_wb_arbiter #(
    parameter int NUM_PIPES  = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = 32,
    parameter int REG_AW     = 5
) (
    input logic               clk_i,
    input logic               rsn_i,
    segre_wb_arbiter_if.slave bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int RR_W  = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1;

    logic [REG_AW-1:0] mem_addr [NUM_PIPES][FIFO_DEPTH];
    logic [DATA_W-1:0] mem_data [NUM_PIPES][FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q [NUM_PIPES];
    logic [PTR_W-1:0]  rd_ptr_q [NUM_PIPES];
    logic [CNT_W-1:0]  count_q  [NUM_PIPES];
    logic [RR_W-1:0]   rr_q;
    logic              rf_we_q;
    logic [REG_AW-1:0] rf_waddr_q;
    logic [DATA_W-1:0] rf_data_q;
    logic              waw_q;

    logic [NUM_PIPES-1:0] full;
    logic [NUM_PIPES-1:0] empty;
    logic [NUM_PIPES-1:0] push;
    logic [NUM_PIPES-1:0] pop;
    logic [REG_AW-1:0]    push_addr [NUM_PIPES];
    logic [DATA_W-1:0]    push_data [NUM_PIPES];
    logic                 slot_vld  [NUM_PIPES][FIFO_DEPTH];
    logic                 gnt_vld;
    logic [RR_W-1:0]      gnt_idx;
    int                   cand;
    logic                 waw_hit;
    logic [REG_AW-1:0]    query [2];
    logic [1:0]           pend;

    // A slot is live when its distance from the read pointer (mod depth) is below the count.
    always_comb begin
        for (int p = 0; p < NUM_PIPES; p++) begin
            push_addr[p] = bus.res_waddr_i[p*REG_AW +: REG_AW];
            push_data[p] = bus.res_data_i[p*DATA_W +: DATA_W];
            full[p]      = (count_q[p] == CNT_W'(FIFO_DEPTH));
            empty[p]     = (count_q[p] == '0);
            push[p]      = bus.res_we_i[p] && !full[p] && (push_addr[p] != '0);
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                slot_vld[p][i] = ({1'b0, PTR_W'(i) - rd_ptr_q[p]} < count_q[p]);
            end
        end
    end

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = rr_q;
        cand    = 0;
        for (int o = 0; o < NUM_PIPES; o++) begin
            cand = int'(rr_q) + o;
            if (cand >= NUM_PIPES) cand = cand - NUM_PIPES;
            if (!gnt_vld && !empty[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = RR_W'(cand);
            end
        end
        pop = '0;
        if (gnt_vld) pop[gnt_idx] = 1'b1;
    end

    // The entry being popped is still live this cycle, so it is covered by the slot scan.
    always_comb begin
        waw_hit = 1'b0;
        for (int p = 0; p < NUM_PIPES; p++) begin
            for (int q = 0; q < NUM_PIPES; q++) begin
                for (int i = 0; i < FIFO_DEPTH; i++) begin
                    if (p != q && push[p] && slot_vld[q][i] && mem_addr[q][i] == push_addr[p]) begin
                        waw_hit = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            query[k] = bus.pend_raddr_i[k*REG_AW +: REG_AW];
            pend[k]  = 1'b0;
            if (query[k] != '0) begin
                if (rf_we_q && rf_waddr_q == query[k]) pend[k] = 1'b1;
                for (int p = 0; p < NUM_PIPES; p++) begin
                    for (int i = 0; i < FIFO_DEPTH; i++) begin
                        if (slot_vld[p][i] && mem_addr[p][i] == query[k]) pend[k] = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            for (int p = 0; p < NUM_PIPES; p++) begin
                wr_ptr_q[p] <= '0;
                rd_ptr_q[p] <= '0;
                count_q[p]  <= '0;
            end
            rr_q       <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_data_q  <= '0;
            waw_q      <= 1'b0;
        end else begin
            for (int p = 0; p < NUM_PIPES; p++) begin
                if (push[p]) wr_ptr_q[p] <= wr_ptr_q[p] + PTR_W'(1);
                if (pop[p])  rd_ptr_q[p] <= rd_ptr_q[p] + PTR_W'(1);
                count_q[p] <= count_q[p] + CNT_W'(push[p]) - CNT_W'(pop[p]);
            end
            rf_we_q <= gnt_vld;
            if (gnt_vld) begin
                rf_waddr_q <= mem_addr[gnt_idx][rd_ptr_q[gnt_idx]];
                rf_data_q  <= mem_data[gnt_idx][rd_ptr_q[gnt_idx]];
                rr_q       <= (gnt_idx == RR_W'(NUM_PIPES - 1)) ? '0 : gnt_idx + RR_W'(1);
            end
            if (waw_hit) waw_q <= 1'b1;
        end
    end

    // Storage needs no reset: liveness comes entirely from the pointers and counts.
    always_ff @(posedge clk_i) begin
        for (int p = 0; p < NUM_PIPES; p++) begin
            if (push[p]) begin
                mem_addr[p][wr_ptr_q[p]] <= push_addr[p];
                mem_data[p][wr_ptr_q[p]] <= push_data[p];
            end
        end
    end

    assign bus.full_o     = full;
    assign bus.rf_we_o    = rf_we_q;
    assign bus.rf_waddr_o = rf_waddr_q;
    assign bus.rf_data_o  = rf_data_q;
    assign bus.pend_o     = pend;
    assign bus.waw_err_o  = waw_q;
endmodule

// File: tb/tb_segre_wb_arbiter.sv
// Bench for segre_wb_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_segre_wb_arbiter;
    localparam int NP = 3;
    localparam int D  = 4;
    localparam int DW = 32;
    localparam int AW = 5;

    logic clk_i = 1'b0;
    logic rsn_i = 1'b1;
    always #5 clk_i = ~clk_i;

    segre_wb_arbiter_if #(.NUM_PIPES(NP), .DATA_W(DW), .REG_AW(AW)) bus ();

    segre_wb_arbiter #(.NUM_PIPES(NP), .FIFO_DEPTH(D), .DATA_W(DW), .REG_AW(AW)) dut (
        .clk_i (clk_i),
        .rsn_i (rsn_i),
        .bus   (bus)
    );

    logic [NP-1:0] we = '0;
    logic [AW-1:0] wa [NP];
    logic [DW-1:0] wd [NP];
    logic [AW-1:0] q1 = '0;
    logic [AW-1:0] q2 = '0;

    assign bus.res_we_i     = we;
    assign bus.res_waddr_i  = {wa[2], wa[1], wa[0]};
    assign bus.res_data_i   = {wd[2], wd[1], wd[0]};
    assign bus.pend_raddr_i = {q2, q1};

    // Reference model: one queue per pipe, round-robin pointer, registered RF outputs.
    logic [AW-1:0] aq [NP][$];
    logic [DW-1:0] dq [NP][$];
    int            rr;
    logic          m_we;
    logic [AW-1:0] m_waddr;
    logic [DW-1:0] m_data;
    logic          m_waw;
    int            m_acc;

    int checks = 0;
    int errors = 0;

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            aq[p].delete();
            dq[p].delete();
        end
        rr = 0; m_we = 1'b0; m_waddr = '0; m_data = '0; m_waw = 1'b0;
    endtask

    function automatic logic [NP-1:0] m_full();
        logic [NP-1:0] f;
        for (int p = 0; p < NP; p++) f[p] = (aq[p].size() == D);
        return f;
    endfunction

    function automatic logic m_pend(logic [AW-1:0] a);
        if (a == '0) return 1'b0;
        if (m_we && m_waddr == a) return 1'b1;
        for (int p = 0; p < NP; p++)
            for (int j = 0; j < aq[p].size(); j++)
                if (aq[p][j] == a) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_edge();
        int g;
        logic [NP-1:0] acc;
        g = -1;
        for (int o = 0; o < NP; o++) begin
            int i;
            i = (rr + o) % NP;
            if (g < 0 && aq[i].size() > 0) g = i;
        end
        for (int p = 0; p < NP; p++) acc[p] = we[p] && (aq[p].size() < D) && (wa[p] != '0);
        for (int p = 0; p < NP; p++)
            for (int q = 0; q < NP; q++)
                if (acc[p] && q != p)
                    for (int j = 0; j < aq[q].size(); j++)
                        if (aq[q][j] == wa[p]) m_waw = 1'b1;
        if (g >= 0) begin
            m_we = 1'b1;
            m_waddr = aq[g].pop_front();
            m_data = dq[g].pop_front();
            rr = (g + 1) % NP;
        end else begin
            m_we = 1'b0;
        end
        for (int p = 0; p < NP; p++)
            if (acc[p]) begin
                aq[p].push_back(wa[p]);
                dq[p].push_back(wd[p]);
                m_acc++;
            end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        we = '0;
    endtask

    task automatic do_reset();
        idle();
        rsn_i = 1'b0;
        #3;
        model_reset();
        @(negedge clk_i);
        rsn_i = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        rsn_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        checks++;
        if (bus.rf_we_o !== 1'b0 || bus.rf_waddr_o !== '0 || bus.rf_data_o !== '0) begin
            errors++;
            $display("FAIL reset_rf: we=%b waddr=%0d data=%h, required 0/0/0", bus.rf_we_o, bus.rf_waddr_o, bus.rf_data_o);
        end
        checks++;
        if (bus.full_o !== 3'b000 || bus.waw_err_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: full=%b waw=%b, required 000/0", bus.full_o, bus.waw_err_o);
        end
        model_reset();
        @(negedge clk_i);
        rsn_i = 1'b1;
    endtask

    task automatic test_single();
        we[0] = 1'b1; wa[0] = 5'd5; wd[0] = 32'hDEAD_BEEF;
        step();
        checks++;
        if (bus.rf_we_o !== 1'b0) begin
            errors++;
            $display("FAIL single_early: rf_we=%b, required 0", bus.rf_we_o);
        end
        idle();
        step();
        checks++;
        if (bus.rf_we_o !== 1'b1 || bus.rf_waddr_o !== 5'd5 || bus.rf_data_o !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL single_write: we=%b waddr=%0d data=%h, required 1/5/deadbeef", bus.rf_we_o, bus.rf_waddr_o, bus.rf_data_o);
        end
        step();
        checks++;
        if (bus.rf_we_o !== 1'b0 || bus.rf_waddr_o !== 5'd5) begin
            errors++;
            $display("FAIL single_pulse: we=%b waddr=%0d, required 0/5", bus.rf_we_o, bus.rf_waddr_o);
        end
    endtask

    task automatic test_all_pipes();
        int nwr;
        logic [NP-1:0] saw_full;
        do_reset();
        nwr = 0; m_acc = 0; saw_full = '0;
        for (int n = 0; n < 32; n++) begin
            if (n < 12) begin
                for (int p = 0; p < NP; p++) begin
                    we[p] = 1'b1;
                    wa[p] = AW'(p * 10 + (n % 8) + 1);
                    wd[p] = {4'(p), 28'(n)};
                end
            end else begin
                idle();
            end
            #1;
            checks++;
            if (bus.full_o !== m_full()) begin
                errors++;
                $display("FAIL all_full n=%0d: full=%b, required %b", n, bus.full_o, m_full());
            end
            saw_full = saw_full | bus.full_o;
            step();
            checks++;
            if (bus.rf_we_o !== m_we || bus.rf_waddr_o !== m_waddr || bus.rf_data_o !== m_data) begin
                errors++;
                $display("FAIL all_rf n=%0d: we=%b waddr=%0d data=%h, required %b/%0d/%h", n, bus.rf_we_o, bus.rf_waddr_o, bus.rf_data_o, m_we, m_waddr, m_data);
            end
            if (bus.rf_we_o === 1'b1) begin
                if (n < 12) begin
                    checks++;
                    if (bus.rf_data_o[31:28] !== 4'(nwr % 3)) begin
                        errors++;
                        $display("FAIL all_order write=%0d: pipe=%0d, required %0d", nwr, bus.rf_data_o[31:28], nwr % 3);
                    end
                end
                nwr++;
            end
        end
        checks++;
        if (saw_full !== 3'b111) begin
            errors++;
            $display("FAIL all_saw_full: seen=%b, required 111", saw_full);
        end
        checks++;
        if (nwr !== m_acc) begin
            errors++;
            $display("FAIL all_count: writes=%0d, required %0d", nwr, m_acc);
        end
    endtask

    task automatic test_full_pushpop();
        int seq;
        int last;
        do_reset();
        seq = 0; last = -1;
        for (int n = 0; n < 40; n++) begin
            idle();
            if (n < 30) begin
                we[1] = 1'b1; wa[1] = AW'(11 + (n % 8)); wd[1] = {4'd1, 28'(seq)};
                seq++;
            end
            if (n < 8) begin
                we[0] = 1'b1; wa[0] = AW'(1 + (n % 8)); wd[0] = {4'd0, 28'(n)};
                we[2] = 1'b1; wa[2] = AW'(21 + (n % 8)); wd[2] = {4'd2, 28'(n)};
            end
            #1;
            checks++;
            if (bus.full_o !== m_full()) begin
                errors++;
                $display("FAIL fpp_full n=%0d: full=%b, required %b", n, bus.full_o, m_full());
            end
            step();
            checks++;
            if (bus.rf_we_o !== m_we || bus.rf_waddr_o !== m_waddr || bus.rf_data_o !== m_data) begin
                errors++;
                $display("FAIL fpp_rf n=%0d: we=%b waddr=%0d data=%h, required %b/%0d/%h", n, bus.rf_we_o, bus.rf_waddr_o, bus.rf_data_o, m_we, m_waddr, m_data);
            end
            if (bus.rf_we_o === 1'b1 && bus.rf_data_o[31:28] === 4'd1) begin
                checks++;
                if (int'(bus.rf_data_o[27:0]) <= last) begin
                    errors++;
                    $display("FAIL fpp_order: seq=%0d after %0d, required increasing", bus.rf_data_o[27:0], last);
                end
                last = int'(bus.rf_data_o[27:0]);
            end
        end
    endtask

    task automatic test_pend();
        do_reset();
        q1 = 5'd7; q2 = 5'd0;
        we[2] = 1'b1; wa[2] = 5'd7; wd[2] = 32'h0000_0777;
        #1;
        checks++;
        if (bus.pend_o !== 2'b00) begin
            errors++;
            $display("FAIL pend_before: pend=%b, required 00", bus.pend_o);
        end
        step();
        idle();
        checks++;
        if (bus.pend_o !== 2'b01) begin
            errors++;
            $display("FAIL pend_queued: pend=%b, required 01", bus.pend_o);
        end
        step();
        checks++;
        if (bus.pend_o !== 2'b01 || bus.rf_we_o !== 1'b1 || bus.rf_waddr_o !== 5'd7) begin
            errors++;
            $display("FAIL pend_writing: pend=%b we=%b waddr=%0d, required 01/1/7", bus.pend_o, bus.rf_we_o, bus.rf_waddr_o);
        end
        step();
        checks++;
        if (bus.pend_o !== 2'b00) begin
            errors++;
            $display("FAIL pend_after: pend=%b, required 00", bus.pend_o);
        end
        q1 = '0;
    endtask

    task automatic test_waw();
        do_reset();
        we[0] = 1'b1; wa[0] = 5'd9; wd[0] = 32'h9;
        step();
        checks++;
        if (bus.waw_err_o !== 1'b0) begin
            errors++;
            $display("FAIL waw_early: waw=%b, required 0", bus.waw_err_o);
        end
        idle();
        we[1] = 1'b1; wa[1] = 5'd9; wd[1] = 32'h19;
        step();
        checks++;
        if (bus.waw_err_o !== 1'b1) begin
            errors++;
            $display("FAIL waw_set: waw=%b, required 1", bus.waw_err_o);
        end
        idle();
        repeat (4) step();
        checks++;
        if (bus.waw_err_o !== 1'b1) begin
            errors++;
            $display("FAIL waw_sticky: waw=%b, required 1", bus.waw_err_o);
        end
        we[0] = 1'b1; wa[0] = 5'd9; q1 = 5'd9;
        step();
        idle();
        rsn_i = 1'b0;
        #1;
        checks++;
        if (bus.waw_err_o !== 1'b0 || bus.rf_we_o !== 1'b0 || bus.rf_waddr_o !== '0 || bus.rf_data_o !== '0 || bus.full_o !== '0 || bus.pend_o !== 2'b00) begin
            errors++;
            $display("FAIL waw_reset: waw=%b we=%b waddr=%0d data=%h full=%b pend=%b, required all zero", bus.waw_err_o, bus.rf_we_o, bus.rf_waddr_o, bus.rf_data_o, bus.full_o, bus.pend_o);
        end
        model_reset();
        q1 = '0;
        @(negedge clk_i);
        rsn_i = 1'b1;
    endtask

    task automatic test_zero_addr();
        do_reset();
        q1 = 5'd3; q2 = 5'd0;
        for (int n = 0; n < 5; n++) begin
            we = 3'b111;
            for (int p = 0; p < NP; p++) begin
                wa[p] = '0;
                wd[p] = $urandom;
            end
            #1;
            checks++;
            if (bus.full_o !== 3'b000 || bus.pend_o !== 2'b00) begin
                errors++;
                $display("FAIL zero_flags n=%0d: full=%b pend=%b, required 000/00", n, bus.full_o, bus.pend_o);
            end
            step();
            checks++;
            if (bus.rf_we_o !== 1'b0) begin
                errors++;
                $display("FAIL zero_write n=%0d: rf_we=%b, required 0", n, bus.rf_we_o);
            end
        end
        idle();
        q1 = '0;
    endtask

    task automatic test_random(input int cycles);
        for (int n = 0; n < cycles; n++) begin
            for (int p = 0; p < NP; p++) begin
                we[p] = ($urandom_range(0, 3) != 0);
                wa[p] = AW'($urandom_range(0, 9));
                wd[p] = $urandom;
            end
            q1 = AW'($urandom_range(0, 9));
            q2 = AW'($urandom_range(0, 9));
            #1;
            checks++;
            if (bus.full_o !== m_full() || bus.pend_o !== {m_pend(q2), m_pend(q1)}) begin
                errors++;
                $display("FAIL rand_comb n=%0d: full=%b pend=%b, required %b/%b", n, bus.full_o, bus.pend_o, m_full(), {m_pend(q2), m_pend(q1)});
            end
            step();
            checks++;
            if (bus.rf_we_o !== m_we || bus.rf_waddr_o !== m_waddr || bus.rf_data_o !== m_data || bus.waw_err_o !== m_waw) begin
                errors++;
                $display("FAIL rand_rf n=%0d: we=%b waddr=%0d data=%h waw=%b, required %b/%0d/%h/%b", n, bus.rf_we_o, bus.rf_waddr_o, bus.rf_data_o, bus.waw_err_o, m_we, m_waddr, m_data, m_waw);
            end
        end
        idle();
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int n = 0; n < 3; n++) begin
            step();
            checks++;
            if (bus.rf_we_o !== 1'b0) begin
                errors++;
                $display("FAIL midreset_write n=%0d: rf_we=%b, required 0", n, bus.rf_we_o);
            end
        end
    endtask

    initial begin
        for (int p = 0; p < NP; p++) begin
            wa[p] = '0;
            wd[p] = '0;
        end
        model_reset();
        m_acc = 0;
        test_reset();
        test_single();
        test_all_pipes();
        test_full_pushpop();
        test_pend();
        test_waw();
        test_zero_addr();
        do_reset();
        test_random(300);
        test_mid_reset();
        test_random(300);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
